// File: rtl/simple_log_writer_if.sv
// Log RAM write-port bundle.
//   mem_wr_val   writer -> RAM  write request
//   mem_wr_addr  writer -> RAM  write address
//   mem_wr_data  writer -> RAM  {timestamp, payload}
//   mem_wr_rdy   RAM -> writer  write accepted when mem_wr_val & mem_wr_rdy
// master: log writer side; slave: RAM side.
interface simple_log_writer_if #(
  parameter int ADDR_W  = 8,
  parameter int ENTRY_W = 96
);
  logic               mem_wr_val;
  logic [ADDR_W-1:0]  mem_wr_addr;
  logic [ENTRY_W-1:0] mem_wr_data;
  logic               mem_wr_rdy;

  modport master (
    output mem_wr_val,
    output mem_wr_addr,
    output mem_wr_data,
    input  mem_wr_rdy
  );

  modport slave (
    input  mem_wr_val,
    input  mem_wr_addr,
    input  mem_wr_data,
    output mem_wr_rdy
  );
endinterface

// File: rtl/simple_log_writer.sv
// Write side of the simple circular log. Probe entries are timestamped with a
// free-running counter and written through a one-entry staging register into
// the log RAM. curr_wr_addr / has_wrapped are exported for the log read path.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   log_en         level: logging enabled
//   log_clear      pulse: restart the log from address 0
//   in_val/in_data probe entry, accepted when in_val & in_rdy
//   in_rdy         probe ready
//   mem            RAM write port (simple_log_writer_if.master)
//   curr_wr_addr   next address to be committed
//   has_wrapped    sticky: a write has committed at the last address
//   log_full       log stopped after one full pass (STOP_ON_FULL only)
//   drop_cnt       saturating count of accepted-but-discarded entries
module simple_log_writer #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 64,
  parameter int TS_W         = 32,
  parameter int STOP_ON_FULL = 0,
  parameter int DROP_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  log_en,
  input  logic                  log_clear,
  input  logic                  in_val,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  in_rdy,
  simple_log_writer_if.master   mem,
  output logic [ADDR_W-1:0]     curr_wr_addr,
  output logic                  has_wrapped,
  output logic                  log_full,
  output logic [DROP_W-1:0]     drop_cnt
);

  localparam int ENTRY_W = TS_W + DATA_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {
    IDLE,
    LOGGING,
    FULL
  } state_t;

  state_t               state;
  logic [TS_W-1:0]      ts;
  logic                 stage_val;
  logic [ENTRY_W-1:0]   stage_data;

  logic                 commit;
  logic                 at_last;
  logic                 accept;
  logic                 sink;

  // The staged entry always targets curr_wr_addr: a commit advances the
  // address in the same cycle a following entry is loaded, so the two stay
  // aligned without a separate staged-address register.
  assign mem.mem_wr_val  = stage_val;
  assign mem.mem_wr_addr = curr_wr_addr;
  assign mem.mem_wr_data = stage_data;
  assign log_full        = (state == FULL);

  always_comb begin
    commit  = stage_val & mem.mem_wr_rdy;
    at_last = (curr_wr_addr == LAST_ADDR);
    in_rdy  = 1'b1;
    if (state == LOGGING) begin
      in_rdy = !stage_val | mem.mem_wr_rdy;
      // Hold off the source while the final entry of the pass is pending.
      if ((STOP_ON_FULL != 0) && stage_val && at_last) begin
        in_rdy = 1'b0;
      end
    end
    accept = (state == LOGGING) & in_val & in_rdy;
    sink   = (state != LOGGING) & in_val;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ts           <= '0;
      curr_wr_addr <= '0;
      has_wrapped  <= 1'b0;
      drop_cnt     <= '0;
      stage_val    <= 1'b0;
      stage_data   <= '0;
    end else begin
      ts <= ts + 1'b1;
      if (log_clear) begin
        // Clear overrides any same-cycle commit, accept or drop.
        curr_wr_addr <= '0;
        has_wrapped  <= 1'b0;
        drop_cnt     <= '0;
        stage_val    <= 1'b0;
        state        <= log_en ? LOGGING : IDLE;
      end else begin
        if (commit) begin
          curr_wr_addr <= curr_wr_addr + 1'b1;
          if (at_last) begin
            has_wrapped <= 1'b1;
          end
        end

        if (accept) begin
          stage_val  <= 1'b1;
          stage_data <= {ts, in_data};
        end else if (commit) begin
          stage_val <= 1'b0;
        end

        if (sink && (drop_cnt != '1)) begin
          drop_cnt <= drop_cnt + 1'b1;
        end

        case (state)
          IDLE: begin
            if (log_en) begin
              state <= LOGGING;
            end
          end
          LOGGING: begin
            if ((STOP_ON_FULL != 0) && commit && at_last) begin
              state <= FULL;
            end else if (!log_en) begin
              state <= IDLE;
            end
          end
          FULL: begin
            state <= FULL;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_simple_log_writer.sv
// Self-checking bench for simple_log_writer. Two instances: A (wrap-around,
// 2-bit drop counter) and B (stop on full).
module tb_simple_log_writer;

  localparam int AW = 2;
  localparam int DW = 16;
  localparam int TW = 16;
  localparam int EW = DW + TW;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [EW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  logic          log_en_a, log_clear_a, in_val_a, in_rdy_a;
  logic [DW-1:0] in_data_a;
  logic [AW-1:0] curr_a;
  logic          wrapped_a, full_a;
  logic [1:0]    drop_a;

  logic          log_en_b, log_clear_b, in_val_b, in_rdy_b;
  logic [DW-1:0] in_data_b;
  logic [AW-1:0] curr_b;
  logic          wrapped_b, full_b;
  logic [3:0]    drop_b;

  simple_log_writer_if #(.ADDR_W(AW), .ENTRY_W(EW)) mem_a ();
  simple_log_writer_if #(.ADDR_W(AW), .ENTRY_W(EW)) mem_b ();

  simple_log_writer #(
    .ADDR_W(AW), .DATA_W(DW), .TS_W(TW), .STOP_ON_FULL(0), .DROP_W(2)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .log_en(log_en_a), .log_clear(log_clear_a),
    .in_val(in_val_a), .in_data(in_data_a), .in_rdy(in_rdy_a), .mem(mem_a),
    .curr_wr_addr(curr_a), .has_wrapped(wrapped_a), .log_full(full_a),
    .drop_cnt(drop_a)
  );

  simple_log_writer #(
    .ADDR_W(AW), .DATA_W(DW), .TS_W(TW), .STOP_ON_FULL(1), .DROP_W(4)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .log_en(log_en_b), .log_clear(log_clear_b),
    .in_val(in_val_b), .in_data(in_data_b), .in_rdy(in_rdy_b), .mem(mem_b),
    .curr_wr_addr(curr_b), .has_wrapped(wrapped_b), .log_full(full_b),
    .drop_cnt(drop_b)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  exp_t          sb_a[$];
  exp_t          sb_b[$];
  logic [AW-1:0] exp_addr_a = '0;
  logic [AW-1:0] exp_addr_b = '0;
  int            writes_a = 0;
  int            writes_b = 0;
  logic [TW-1:0] commit_ts_a[$];
  logic [TW-1:0] ts_model;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference timestamp: zero in reset, +1 per clock afterwards.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts_model <= '0;
    else        ts_model <= ts_model + 1'b1;
  end

  always @(negedge clk) begin
    if (rst_n && mem_a.mem_wr_val && mem_a.mem_wr_rdy) begin
      exp_t e;
      writes_a++;
      commit_ts_a.push_back(ts_model);
      chk("write_expected_a", 64'(sb_a.size() != 0), 64'd1);
      if (sb_a.size() != 0) begin
        e = sb_a.pop_front();
        chk("wr_addr_a", 64'(mem_a.mem_wr_addr), 64'(e.addr));
        chk("wr_data_a", 64'(mem_a.mem_wr_data), 64'(e.data));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && mem_b.mem_wr_val && mem_b.mem_wr_rdy) begin
      exp_t e;
      writes_b++;
      chk("write_expected_b", 64'(sb_b.size() != 0), 64'd1);
      if (sb_b.size() != 0) begin
        e = sb_b.pop_front();
        chk("wr_addr_b", 64'(mem_b.mem_wr_addr), 64'(e.addr));
        chk("wr_data_b", 64'(mem_b.mem_wr_data), 64'(e.data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one entry; if it is expected to be logged, push it to the scoreboard
  // with the timestamp of the accepting edge.
  task automatic send(input bit b, input logic [DW-1:0] d, input bit logged);
    int n;
    logic rdy;
    exp_t e;
    if (b) begin in_val_b = 1'b1; in_data_b = d; end
    else   begin in_val_a = 1'b1; in_data_a = d; end
    n = 0;
    @(negedge clk);
    rdy = b ? in_rdy_b : in_rdy_a;
    while (!rdy && n < 40) begin
      @(negedge clk);
      rdy = b ? in_rdy_b : in_rdy_a;
      n++;
    end
    chk("send_in_rdy", 64'(rdy), 64'd1);
    if (rdy && logged) begin
      if (b) begin
        e.addr = exp_addr_b; e.data = {ts_model, d};
        sb_b.push_back(e); exp_addr_b++;
      end else begin
        e.addr = exp_addr_a; e.data = {ts_model, d};
        sb_a.push_back(e); exp_addr_a++;
      end
    end
    @(posedge clk);
    #1;
    if (b) in_val_b = 1'b0;
    else   in_val_a = 1'b0;
  endtask

  task automatic wait_drain(input bit b);
    int n;
    n = 0;
    while ((b ? sb_b.size() : sb_a.size()) != 0 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("drain", 64'(b ? sb_b.size() : sb_a.size()), 64'd0);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int w0;
    exp_t e;
    rst_n = 1'b0;
    log_en_a = 0; log_clear_a = 0; in_val_a = 0; in_data_a = '0;
    log_en_b = 0; log_clear_b = 0; in_val_b = 0; in_data_b = '0;
    mem_a.mem_wr_rdy = 1'b1;
    mem_b.mem_wr_rdy = 1'b1;
    #2;
    chk("rst_curr", 64'(curr_a), 64'd0);
    chk("rst_wrapped", 64'(wrapped_a), 64'd0);
    chk("rst_full", 64'(full_a), 64'd0);
    chk("rst_drop", 64'(drop_a), 64'd0);
    chk("rst_wr_val", 64'(mem_a.mem_wr_val), 64'd0);
    chk("rst_wr_addr", 64'(mem_a.mem_wr_addr), 64'd0);
    chk("rst_wr_data", 64'(mem_a.mem_wr_data), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // 1: three back-to-back entries
    log_en_a = 1'b1;
    tick();
    send(0, 16'hA001, 1);
    send(0, 16'hA002, 1);
    send(0, 16'hA003, 1);
    wait_drain(0);
    chk("t1_curr", 64'(curr_a), 64'd3);
    chk("t1_writes", 64'(commit_ts_a.size()), 64'd3);
    if (commit_ts_a.size() == 3) begin
      chk("t1_gap0", 64'(commit_ts_a[1] - commit_ts_a[0]), 64'd1);
      chk("t1_gap1", 64'(commit_ts_a[2] - commit_ts_a[1]), 64'd1);
    end

    // 2: wrap-around overwrite
    log_clear_a = 1'b1;
    tick();
    log_clear_a = 1'b0;
    exp_addr_a = '0;
    chk("t2_clear_curr", 64'(curr_a), 64'd0);
    for (int i = 0; i < 3; i++) send(0, 16'hB000 + 16'(i), 1);
    wait_drain(0);
    chk("t2_wrapped_before", 64'(wrapped_a), 64'd0);
    send(0, 16'hB003, 1);
    wait_drain(0);
    chk("t2_wrapped_after", 64'(wrapped_a), 64'd1);
    send(0, 16'hB004, 1);
    send(0, 16'hB005, 1);
    wait_drain(0);
    chk("t2_curr", 64'(curr_a), 64'd2);

    // 4: back-pressure holds the staged entry
    mem_a.mem_wr_rdy = 1'b0;
    send(0, 16'hC0DE, 1);
    e = sb_a[0];
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_val", 64'(mem_a.mem_wr_val), 64'd1);
      chk("t4_addr", 64'(mem_a.mem_wr_addr), 64'(e.addr));
      chk("t4_data", 64'(mem_a.mem_wr_data), 64'(e.data));
      chk("t4_in_rdy", 64'(in_rdy_a), 64'd0);
    end
    tick();
    mem_a.mem_wr_rdy = 1'b1;
    wait_drain(0);
    chk("t4_curr", 64'(curr_a), 64'd3);

    // 6: disabled logging drops entries, counter saturates
    log_en_a = 1'b0;
    tick();
    w0 = writes_a;
    for (int i = 0; i < 3; i++) send(0, 16'hD000 + 16'(i), 0);
    chk("t6_drop3", 64'(drop_a), 64'd3);
    for (int i = 0; i < 5; i++) send(0, 16'hD100 + 16'(i), 0);
    chk("t6_drop_sat", 64'(drop_a), 64'd3);
    chk("t6_no_writes", 64'(writes_a - w0), 64'd0);
    chk("t6_curr", 64'(curr_a), 64'd3);

    // 5: clear with a staged entry and a same-cycle probe entry
    log_en_a = 1'b1;
    tick();
    mem_a.mem_wr_rdy = 1'b0;
    send(0, 16'hE000, 1);
    w0 = writes_a;
    log_clear_a = 1'b1;
    in_val_a = 1'b1;
    in_data_a = 16'hE001;
    tick();
    log_clear_a = 1'b0;
    in_val_a = 1'b0;
    sb_a.delete();
    exp_addr_a = '0;
    mem_a.mem_wr_rdy = 1'b1;
    chk("t5_wr_val", 64'(mem_a.mem_wr_val), 64'd0);
    chk("t5_curr", 64'(curr_a), 64'd0);
    chk("t5_wrapped", 64'(wrapped_a), 64'd0);
    chk("t5_drop", 64'(drop_a), 64'd0);
    tick();
    chk("t5_no_write", 64'(writes_a - w0), 64'd0);
    send(0, 16'hE002, 1);
    wait_drain(0);
    chk("t5_curr_after", 64'(curr_a), 64'd1);

    // 3: stop on full (instance B)
    log_en_b = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) send(1, 16'hF000 + 16'(i), i < 4);
    wait_drain(1);
    chk("t3_writes", 64'(writes_b), 64'd4);
    chk("t3_full", 64'(full_b), 64'd1);
    chk("t3_drop", 64'(drop_b), 64'd2);
    chk("t3_curr", 64'(curr_b), 64'd0);
    chk("t3_wrapped", 64'(wrapped_b), 64'd1);

    // Async reset while a write is pending
    mem_a.mem_wr_rdy = 1'b0;
    send(0, 16'h5A5A, 1);
    #3;
    rst_n = 1'b0;
    #1;
    sb_a.delete();
    exp_addr_a = '0;
    chk("arst_wr_val", 64'(mem_a.mem_wr_val), 64'd0);
    chk("arst_wr_data", 64'(mem_a.mem_wr_data), 64'd0);
    chk("arst_curr", 64'(curr_a), 64'd0);
    chk("arst_wrapped_b", 64'(wrapped_b), 64'd0);
    chk("arst_full_b", 64'(full_b), 64'd0);
    chk("arst_drop_b", 64'(drop_b), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
